// File: rtl/present_cipher_core_if.sv
// present_cipher_core_if: request/result handshake bundle for the PRESENT cipher core.
// Signals:
//   in_valid/in_ready/in_mode/in_key[KEY_W]/in_block[64]  request side (master drives the request)
//   out_valid/out_ready/out_block[64]                     result side (slave drives the result)
//   busy                                                  core not idle
// Modports: master = requester/consumer, slave = cipher core.
interface present_cipher_core_if #(
    parameter int KEY_W = 80
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [KEY_W-1:0] in_key;
    logic [63:0]      in_block;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_block;
    logic             busy;
    modport master (
        output in_valid, in_mode, in_key, in_block, out_ready,
        input  in_ready, out_valid, out_block, busy
    );
    modport slave (
        input  in_valid, in_mode, in_key, in_block, out_ready,
        output in_ready, out_valid, out_block, busy
    );
endinterface

// File: rtl/present_cipher_core.sv
// present_cipher_core: iterative PRESENT encrypt/decrypt engine, one round per clock.
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous, active-low reset; aborts any operation in flight
//   bus    present_cipher_core_if.slave: request (in_*), result (out_*), busy
// Parameters: KEY_W (80 or 128), ROUNDS (1..31).
// Optional feature: define PRESENT_DEC_KEY_CACHE_EN to keep the last key and its final
//   round key, so a decrypt with the same key skips the forward key-prep pass.
module present_cipher_core #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input logic Clock,
    input logic Reset,
    present_cipher_core_if.slave bus
);
    localparam int          CTR_LO   = (KEY_W == 128) ? 62 : 15;
    localparam logic [4:0]  LAST     = 5'(ROUNDS);
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $fatal(1, "present_cipher_core: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $fatal(1, "present_cipher_core: ROUNDS must be 1..31");
    end

    typedef enum logic [2:0] {IDLE, KEYPREP, ROUND, FINAL, DONE} state_t;

    function automatic logic [3:0] sb(input logic [63:0] t, input logic [3:0] x);
        return t[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] t, input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sb(t, s[4*n +: 4]);
        return r;
    endfunction

    // Bit b moves to 16*b mod 63 (bit 63 fixed), written as (b%4)*16 + b/4.
    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) r[(b % 4) * 16 + b / 4] = s[b];
        return r;
    endfunction

    function automatic logic [63:0] p_inv(input logic [63:0] s);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) r[b] = s[(b % 4) * 16 + b / 4];
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] key_upd(input logic [KEY_W-1:0] k, input logic [4:0] i);
        logic [KEY_W-1:0] r;
        r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sb(SBOX, r[KEY_W-1 -: 4]);
        if (KEY_W == 128) r[KEY_W-5 -: 4] = sb(SBOX, r[KEY_W-5 -: 4]);
        r[CTR_LO +: 5] = r[CTR_LO +: 5] ^ i;
        return r;
    endfunction

    // Undo key_upd step by step: counter, S-box(es), then rotate right by 61.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] i);
        logic [KEY_W-1:0] r;
        r = k;
        r[CTR_LO +: 5] = r[CTR_LO +: 5] ^ i;
        if (KEY_W == 128) r[KEY_W-5 -: 4] = sb(SBOX_INV, r[KEY_W-5 -: 4]);
        r[KEY_W-1 -: 4] = sb(SBOX_INV, r[KEY_W-1 -: 4]);
        return {r[60:0], r[KEY_W-1:61]};
    endfunction

    state_t           state_q, state_d;
    logic [63:0]      st_q, st_d;
    logic [KEY_W-1:0] kr_q, kr_d;
    logic [4:0]       rnd_q, rnd_d;
    logic             mode_q, mode_d;
    logic [63:0]      out_block_q, out_block_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      rk;
`ifdef PRESENT_DEC_KEY_CACHE_EN
    logic             cache_vld_q, cache_vld_d;
    logic [KEY_W-1:0] cache_key_q, cache_key_d;
    logic [KEY_W-1:0] cache_fin_q, cache_fin_d;
`endif

    assign rk            = kr_q[KEY_W-1 -: 64];
    assign bus.in_ready  = (state_q == IDLE) && Reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
    assign bus.busy      = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        kr_d        = kr_q;
        rnd_d       = rnd_q;
        mode_d      = mode_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
`ifdef PRESENT_DEC_KEY_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
        cache_fin_d = cache_fin_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid && bus.in_ready) begin
                st_d    = bus.in_block;
                kr_d    = bus.in_key;
                rnd_d   = 5'd1;
                mode_d  = bus.in_mode;
                state_d = bus.in_mode ? KEYPREP : ROUND;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                // The key is captured now and the entry invalidated; the final round key
                // is filled in later, which leaves the same contents as a late fill.
                if (bus.in_mode && cache_vld_q && bus.in_key == cache_key_q) begin
                    kr_d    = cache_fin_q;
                    rnd_d   = LAST;
                    state_d = ROUND;
                end else begin
                    cache_key_d = bus.in_key;
                    cache_vld_d = 1'b0;
                end
`endif
            end
            KEYPREP: begin
                kr_d  = key_upd(kr_q, rnd_q);
                rnd_d = rnd_q + 5'd1;
                if (rnd_q == LAST) begin
                    rnd_d   = LAST;
                    state_d = ROUND;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                    cache_fin_d = kr_d;
                    cache_vld_d = 1'b1;
`endif
                end
            end
            ROUND: begin
                st_d  = mode_q ? s_layer(SBOX_INV, p_inv(st_q ^ rk)) : p_layer(s_layer(SBOX, st_q ^ rk));
                kr_d  = mode_q ? key_inv(kr_q, rnd_q) : key_upd(kr_q, rnd_q);
                rnd_d = mode_q ? rnd_q - 5'd1 : rnd_q + 5'd1;
                if (rnd_q == (mode_q ? 5'd1 : LAST)) state_d = FINAL;
            end
            FINAL: begin
                out_block_d = st_q ^ rk;
                out_valid_d = 1'b1;
                state_d     = DONE;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                if (!mode_q) begin
                    cache_fin_d = kr_q;
                    cache_vld_d = 1'b1;
                end
`endif
            end
            DONE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            kr_q        <= '0;
            rnd_q       <= '0;
            mode_q      <= 1'b0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_fin_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            kr_q        <= kr_d;
            rnd_q       <= rnd_d;
            mode_q      <= mode_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
            cache_fin_q <= cache_fin_d;
`endif
        end
    end
endmodule
